// File: rtl/mac_core_param.sv
// Parametrised multiply-accumulate core: 2-stage pipeline (multiply, accumulate)
// over NUM_ACC accumulators, with saturation, sticky overflow and a back-pressured result port.
module mac_core_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned NUM_ACC = 4,
  parameter bit          SAT_EN  = 1'b1,
  localparam int unsigned SEL_W  = $clog2(NUM_ACC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         opcode,
  input  logic [SEL_W-1:0]   acc_sel,
  input  logic [DATA_W-1:0]  op_a,
  input  logic [DATA_W-1:0]  op_b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic [NUM_ACC-1:0] ovf_flag,
  output logic [1:0]         state_dbg
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_MAC   = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_CLEAR = 3'b100;
  localparam logic [2:0] OP_READ  = 3'b101;
  localparam logic [2:0] OP_RDCLR = 3'b110;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_STALL = 2'd2} state_t;

  logic [ACC_W-1:0]  acc [NUM_ACC];

  logic              s1_valid, s2_valid;
  logic [2:0]        s1_op, s2_op;
  logic [SEL_W-1:0]  s1_sel, s2_sel;
  logic [ACC_W-1:0]  s1_val, s2_val;

  logic [PROD_W-1:0] prod_u;
  logic [PROD_W-1:0] prod_s;
  logic [ACC_W-1:0]  cmd_val;

  logic [ACC_W-1:0]  acc_cur;
  logic [ACC_W:0]    acc_ext, val_ext, sum;
  logic              ovf;
  logic [ACC_W-1:0]  sat_val;
  logic              acc_wr, flag_set, flag_clr, rd;
  logic [ACC_W-1:0]  acc_nxt;
  logic              stall;

  // S1 operand: extended op_a for LOAD, otherwise the extended product
  assign prod_u = PROD_W'(op_a) * PROD_W'(op_b);
  assign prod_s = {{DATA_W{op_a[DATA_W-1]}}, op_a} * {{DATA_W{op_b[DATA_W-1]}}, op_b};

  always_comb begin
    cmd_val = '0;
    if (opcode == OP_LOAD) begin
      cmd_val = signed_mode ? {{(ACC_W-DATA_W){op_a[DATA_W-1]}}, op_a} : ACC_W'(op_a);
    end else begin
      cmd_val = signed_mode ? {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s} : ACC_W'(prod_u);
    end
  end

  // S2 arithmetic at ACC_W+1 bits; overflow when the two top bits disagree
  assign acc_cur = acc[s2_sel];
  assign acc_ext = {acc_cur[ACC_W-1], acc_cur};
  assign val_ext = {s2_val[ACC_W-1], s2_val};
  assign sum     = (s2_op == OP_MSUB) ? acc_ext - val_ext : acc_ext + val_ext;
  assign ovf     = sum[ACC_W] != sum[ACC_W-1];
  assign sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};

  always_comb begin
    acc_wr   = 1'b0;
    acc_nxt  = acc_cur;
    flag_set = 1'b0;
    flag_clr = 1'b0;
    rd       = 1'b0;
    if (s2_valid) begin
      case (s2_op)
        OP_LOAD:  begin acc_wr = 1'b1; acc_nxt = s2_val; flag_clr = 1'b1; end
        OP_MAC, OP_MSUB: begin
          acc_wr   = 1'b1;
          acc_nxt  = (ovf && SAT_EN) ? sat_val : sum[ACC_W-1:0];
          flag_set = ovf;
        end
        OP_CLEAR: begin acc_wr = 1'b1; acc_nxt = '0; flag_clr = 1'b1; end
        OP_READ:  rd = 1'b1;
        OP_RDCLR: begin rd = 1'b1; acc_wr = 1'b1; acc_nxt = '0; flag_clr = 1'b1; end
        default:  ;
      endcase
    end
  end

  // A pending result that cannot drain blocks the READ in S2, freezing the whole core
  assign stall    = s2_valid && (s2_op == OP_READ || s2_op == OP_RDCLR) && out_valid && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    if (stall)                               state_dbg = ST_STALL;
    else if (s1_valid || s2_valid || out_valid) state_dbg = ST_RUN;
    else                                     state_dbg = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_ACC; k++) acc[k] <= '0;
      ovf_flag  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_sel    <= '0;
      s1_val    <= '0;
      s2_valid  <= 1'b0;
      s2_op     <= '0;
      s2_sel    <= '0;
      s2_val    <= '0;
    end else if (!stall) begin
      if (acc_wr) acc[s2_sel] <= acc_nxt;
      if (flag_clr)      ovf_flag[s2_sel] <= 1'b0;
      else if (flag_set) ovf_flag[s2_sel] <= 1'b1;

      if (rd) begin
        out_valid <= 1'b1;
        out_data  <= acc_cur;
        out_sel   <= s2_sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      s2_valid <= s1_valid;
      s2_op    <= s1_op;
      s2_sel   <= s1_sel;
      s2_val   <= s1_val;

      s1_valid <= in_valid;
      s1_op    <= opcode;
      s1_sel   <= acc_sel;
      s1_val   <= cmd_val;
    end
  end

endmodule

// File: tb/tb_mac_core_param.sv
// Self-checking bench for mac_core_param: directed scenarios plus randomized traffic
// compared against a command-level arithmetic model of the accumulators.
module tb_mac_core_param;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ACC_W   = 24;
  localparam int unsigned NUM_ACC = 4;
  localparam int unsigned SEL_W   = 2;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

  localparam logic [2:0] OP_NOP = 3'd0, OP_LOAD = 3'd1, OP_MAC = 3'd2, OP_MSUB = 3'd3,
                         OP_CLEAR = 3'd4, OP_READ = 3'd5, OP_RDCLR = 3'd6;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready;
  logic [2:0]         opcode;
  logic [SEL_W-1:0]   acc_sel;
  logic [DATA_W-1:0]  op_a, op_b;
  logic               signed_mode;
  logic               out_valid, out_ready;
  logic [ACC_W-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic [NUM_ACC-1:0] ovf_flag;
  logic [1:0]         state_dbg;

  mac_core_param #(.DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_ACC(NUM_ACC), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .acc_sel(acc_sel), .op_a(op_a), .op_b(op_b), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
    .ovf_flag(ovf_flag), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit last_acc;

  // Reference state: one integer per accumulator, flags, and expected result stream
  longint                   m_acc [NUM_ACC];
  logic [NUM_ACC-1:0]       m_flag;
  logic [SEL_W+ACC_W-1:0]   exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint operand(input logic [DATA_W-1:0] v, input bit sm);
    if (sm && v[DATA_W-1]) return longint'(v) - (longint'(1) <<< DATA_W);
    return longint'(v);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NUM_ACC; k++) m_acc[k] = 0;
    m_flag = '0;
    exp_q.delete();
  endfunction

  function automatic void model_cmd(input logic [2:0] op, input logic [SEL_W-1:0] sel,
                                    input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                    input bit sm);
    longint va, p, r;
    logic [63:0] t;
    va = operand(a, sm);
    p  = va * operand(b, sm);
    r  = m_acc[sel];
    t  = 64'(r);
    case (op)
      OP_LOAD:  begin m_acc[sel] = va; m_flag[sel] = 1'b0; end
      OP_MAC, OP_MSUB: begin
        r = (op == OP_MAC) ? r + p : r - p;
        if (r > ACC_MAX) begin r = ACC_MAX; m_flag[sel] = 1'b1; end
        if (r < ACC_MIN) begin r = ACC_MIN; m_flag[sel] = 1'b1; end
        m_acc[sel] = r;
      end
      OP_CLEAR: begin m_acc[sel] = 0; m_flag[sel] = 1'b0; end
      OP_READ:  exp_q.push_back({sel, t[ACC_W-1:0]});
      OP_RDCLR: begin
        exp_q.push_back({sel, t[ACC_W-1:0]});
        m_acc[sel] = 0;
        m_flag[sel] = 1'b0;
      end
      default: ;
    endcase
  endfunction

  // One clock: record handshakes at the falling edge, return just after the rising edge
  task automatic tick();
    logic [SEL_W+ACC_W-1:0] e;
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (last_acc) model_cmd(opcode, acc_sel, op_a, op_b, signed_mode);
    if (out_valid && out_ready) begin
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_result: observed sel=%0d data=0x%0h expected no result", out_sel, out_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result_data", 64'(out_data), 64'(e[ACC_W-1:0]));
        check("result_sel", 64'(out_sel), 64'(e[SEL_W+ACC_W-1:ACC_W]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input int sel, input int a, input int b, input bit sm);
    bit done = 1'b0;
    opcode = op; acc_sel = SEL_W'(sel); op_a = DATA_W'(a); op_b = DATA_W'(b);
    signed_mode = sm; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      tick();
      done = last_acc;
    end
    in_valid = 1'b0;
    n_assert++;
    assert (done) else begin
      n_fail++;
      $error("FAIL accept_timeout: observed not accepted expected accepted (op=%0d)", op);
    end
  endtask

  task automatic drain();
    bit idle = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      tick();
      idle = (state_dbg == 2'd0) && (exp_q.size() == 0);
    end
    n_assert++;
    assert (idle) else begin
      n_fail++;
      $error("FAIL drain_timeout: observed state_dbg=%0d pending=%0d expected idle", state_dbg, exp_q.size());
    end
  endtask

  // Issue a read on an idle core and check the result appears exactly two edges after acceptance
  task automatic read_expect(input logic [2:0] op, input int sel, input logic [ACC_W-1:0] expv,
                             input string tag);
    send(op, sel, 0, 0, 1'b0);
    tick();
    check({tag, "_early"}, 64'(out_valid), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(out_data), 64'(expv));
    check({tag, "_sel"}, 64'(out_sel), 64'(sel));
    drain();
  endtask

  initial begin
    in_valid = 1'b0; opcode = OP_NOP; acc_sel = '0; op_a = '0; op_b = '0;
    signed_mode = 1'b0; out_ready = 1'b1;
    model_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_ovf", 64'(ovf_flag), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    // LOAD then READ with latency check
    send(OP_LOAD, 0, 'h41, 0, 1'b0);
    read_expect(OP_READ, 0, 24'h000041, "load_read");

    // Mixed signed/unsigned MACs
    send(OP_CLEAR, 1, 0, 0, 1'b0);
    send(OP_MAC, 1, 'hFF, 'hAA, 1'b1);
    send(OP_MAC, 1, 'h55, 'h11, 1'b0);
    read_expect(OP_READ, 1, 24'h0005FB, "mixed_mac");
    check("mixed_ovf", 64'(ovf_flag), 64'd0);

    // Back-to-back MACs to one accumulator
    send(OP_CLEAR, 3, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) send(OP_MAC, 3, 2, 3, 1'b0);
    read_expect(OP_READ, 3, 24'h000018, "b2b_mac");

    // Positive saturation, sticky flag, READ_CLEAR
    send(OP_CLEAR, 2, 0, 0, 1'b0);
    for (int i = 0; i < 130; i++) send(OP_MAC, 2, 'hFF, 'hFF, 1'b0);
    drain();
    check("sat_flag", 64'(ovf_flag[2]), 64'd1);
    read_expect(OP_READ, 2, 24'h7FFFFF, "sat_read");
    read_expect(OP_RDCLR, 2, 24'h7FFFFF, "sat_rdclr");
    read_expect(OP_READ, 2, 24'h000000, "after_rdclr");
    check("flag_cleared", 64'(ovf_flag[2]), 64'd0);

    // Back-pressure: results held, input stalled, nothing lost
    out_ready = 1'b0;
    send(OP_LOAD, 0, 5, 0, 1'b0);
    send(OP_LOAD, 1, 7, 0, 1'b0);
    send(OP_READ, 0, 0, 0, 1'b0);
    send(OP_READ, 1, 0, 0, 1'b0);
    send(OP_MAC, 0, 3, 4, 1'b0);
    tick();
    tick();
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_data", 64'(out_data), 64'h000005);
    check("stall_sel", 64'(out_sel), 64'd0);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_state", 64'(state_dbg), 64'd2);
    out_ready = 1'b1;
    drain();
    read_expect(OP_READ, 0, 24'h000011, "post_stall_mac");

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      in_valid    = 1'($urandom_range(0, 3) != 0);
      opcode      = 3'($urandom_range(0, 7));
      acc_sel     = SEL_W'($urandom_range(0, NUM_ACC - 1));
      op_a        = DATA_W'($urandom);
      op_b        = DATA_W'($urandom);
      signed_mode = 1'($urandom_range(0, 1));
      out_ready   = 1'($urandom_range(0, 9) < 7);
      tick();
    end
    out_ready = 1'b1;
    drain();
    check("rand_ovf", 64'(ovf_flag), 64'(m_flag));
    for (int k = 0; k < NUM_ACC; k++) send(OP_READ, k, 0, 0, 1'b0);
    drain();

    // Asynchronous reset while stalled with a pending result
    send(OP_CLEAR, 3, 0, 0, 1'b0);
    for (int i = 0; i < 130; i++) send(OP_MAC, 3, 'hFF, 'hFF, 1'b0);
    drain();
    check("pre_rst_flag", 64'(ovf_flag[3]), 64'd1);
    out_ready = 1'b0;
    send(OP_READ, 0, 0, 0, 1'b0);
    send(OP_READ, 1, 0, 0, 1'b0);
    tick();
    tick();
    check("pre_rst_stall", 64'(state_dbg), 64'd2);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_ovf", 64'(ovf_flag), 64'd0);
    check("async_state", 64'(state_dbg), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk) #1;
    for (int k = 0; k < NUM_ACC; k++) read_expect(OP_READ, k, 24'h000000, "rst_acc");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
